// File: rtl/register_file.sv
// cotm32 integer register file: N read ports, one write port, x0 reads zero.
// Optional same-cycle write-to-read forwarding under COTM32_REGFILE_BYPASS_EN.
package cotm32_pkg;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
endpackage

module register_file
    import cotm32_pkg::*;
#(
    parameter int N_RPORTS = 2,
    parameter int N_REGS   = NUM_REGS,
    localparam int AW      = $clog2(N_REGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr [0:N_RPORTS-1],
    output logic [XLEN-1:0] o_rdata [0:N_RPORTS-1]
);

    // x0 has no storage; indices outside 1..N_REGS-1 simply never match
    logic [XLEN-1:0] regs [1:N_REGS-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 1; r < N_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (i_we) begin
            for (int r = 1; r < N_REGS; r++) begin
                if (i_waddr == AW'(r)) begin
                    regs[r] <= i_wdata;
                end
            end
        end
    end

`ifdef COTM32_REGFILE_BYPASS_EN
    logic waddr_hit;

    always_comb begin
        waddr_hit = 1'b0;
        for (int r = 1; r < N_REGS; r++) begin
            if (i_waddr == AW'(r)) begin
                waddr_hit = 1'b1;
            end
        end
    end

    logic fwd;
    assign fwd = i_rst_n && i_we && waddr_hit;
`endif

    always_comb begin
        for (int p = 0; p < N_RPORTS; p++) begin
            o_rdata[p] = '0;
            for (int r = 1; r < N_REGS; r++) begin
                if (i_raddr[p] == AW'(r)) begin
                    o_rdata[p] = regs[r];
                end
            end
`ifdef COTM32_REGFILE_BYPASS_EN
            if (fwd && (i_raddr[p] == i_waddr)) begin
                o_rdata[p] = i_wdata;
            end
`endif
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data,
// a monitor process pops and compares each time a sample is strobed.
module tb_register_file;
    import cotm32_pkg::*;

    localparam int NP = 2;
    localparam int AW = $clog2(NUM_REGS);

    logic            clk;
    logic            rst_n;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr [0:NP-1];
    logic [XLEN-1:0] rdata [0:NP-1];

    typedef struct {
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_chk;
    int   n_fail;

    register_file #(.N_RPORTS(NP)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_raddr (raddr),
        .o_rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: compare every queued expectation at each sample strobe
    initial begin
        forever begin
            @(sample_ev);
            #1;
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if (rdata[e.port] !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: port %0d got %h expected %h",
                             e.name, e.port, rdata[e.port], e.exp);
                end
            end
        end
    end

    task automatic expect_rd(input int p, input logic [31:0] v,
                             input string nm);
        exp_t e;
        e.port = p;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic sample();
        -> sample_ev;
        #2;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd2(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input string nm);
        raddr[0] = a0;
        raddr[1] = a1;
        expect_rd(0, e0, nm);
        expect_rd(1, e1, nm);
        sample();
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        raddr[0] = 5'd1;
        raddr[1] = 5'd31;
        #12;
        rd2(5'd1, 5'd31, 32'h0, 32'h0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        wr(5'd1, 32'h12345600);
        rd2(5'd1, 5'd0, 32'h12345600, 32'h0, "wr_x1");

        wr(5'd15, 32'hABCDEF00);
        rd2(5'd1, 5'd15, 32'h12345600, 32'hABCDEF00, "wr_x15");

        wr(5'd31, 32'hAABBCCDD);
        rd2(5'd31, 5'd1, 32'hAABBCCDD, 32'h12345600, "wr_x31");

        wr(5'd0, 32'hCCDDEEFF);
        rd2(5'd0, 5'd0, 32'h0, 32'h0, "wr_x0_dropped");

        rd2(5'd15, 5'd15, 32'hABCDEF00, 32'hABCDEF00, "same_index");

        // back-to-back writes to x2 with we held high
        @(negedge clk);
        we       = 1'b1;
        waddr    = 5'd2;
        wdata    = 32'd1;
        raddr[0] = 5'd2;
        raddr[1] = 5'd1;
`ifdef COTM32_REGFILE_BYPASS_EN
        expect_rd(0, 32'd1, "pre_edge_bypass");
`else
        expect_rd(0, 32'd0, "pre_edge_old");
`endif
        sample();
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            expect_rd(0, 32'(k), $sformatf("consec_wr_%0d", k));
            expect_rd(1, 32'h12345600, "consec_other_port");
            sample();
            @(negedge clk);
            wdata = 32'(k + 1);
        end
        we = 1'b0;

        // asynchronous reset between edges, with a write attempted
        @(negedge clk);
        #2;
        we    = 1'b1;
        waddr = 5'd5;
        wdata = 32'h55555555;
        rst_n = 1'b0;
        #1;
        rd2(5'd1, 5'd31, 32'h0, 32'h0, "async_rst_immediate");
        rd2(5'd5, 5'd15, 32'h0, 32'h0, "rst_no_fwd");
        @(posedge clk);
        @(negedge clk);
        rd2(5'd5, 5'd2, 32'h0, 32'h0, "rst_write_ignored");
        we    = 1'b0;
        rst_n = 1'b1;
        rd2(5'd1, 5'd15, 32'h0, 32'h0, "post_rst_x1_x15");
        rd2(5'd31, 5'd5, 32'h0, 32'h0, "post_rst_x31_x5");

        wr(5'd7, 32'hDEADBEEF);
        rd2(5'd7, 5'd1, 32'hDEADBEEF, 32'h0, "first_wr_after_rst");

        #5;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Multi-read-port, single-write-port integer register file for the cotm32 core, holding the architectural general-purpose registers x0..x(N_REGS-1). Register x0 is hardwired to zero. Reads are combinational from any number of ports, and writes commit on the rising clock edge. It sits between decode (read addresses), the operand path (read data) and writeback (write port).

## Interface
- `N_RPORTS`, default 2: number of independent read ports.
- `N_REGS`, default `NUM_REGS` (cotm32_pkg, 32): number of registers, including x0.
- Derived: `AW = $clog2(N_REGS)`; data width is `XLEN` from cotm32_pkg (32).

Ports:
- `i_clk`  in  1  clock; writes commit on rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `i_we`  in  1  write enable.
- `i_waddr`  in  AW  write register index.
- `i_wdata`  in  XLEN  write data.
- `i_raddr`  in  AW x [0:N_RPORTS-1]  unpacked array of read indices.
- `o_rdata`  out  XLEN x [0:N_RPORTS-1]  unpacked array of read data, one per port.

## Operation
- Storage: registers 1..N_REGS-1, each XLEN bits. x0 has no storage and always reads 0.
- Write: on `posedge i_clk`, if `i_we`=1, `i_waddr`!=0 and `i_waddr`<N_REGS, then reg[i_waddr] <= i_wdata.
  - Writes to x0 or to an out-of-range index are silently dropped.
- Read: `o_rdata[p]` = 0 if `i_raddr[p]`==0 or `i_raddr[p]`>=N_REGS; otherwise it is reg[i_raddr[p]]. Read is purely combinational.
- Ports are fully independent. Any number of ports may read the same index simultaneously.
- Reset: while `i_rst_n`=0, all registers are cleared to 0 immediately, without waiting for a clock edge. Writes are ignored during reset. Every `o_rdata[p]` reads 0 for every address during reset.
- Reset deassertion mid-operation: the first write takes effect at the first rising edge with `i_rst_n`=1.

## Timing
- Write latency: 1 edge. Data presented before rising edge N is readable combinationally immediately after edge N.
- Read latency: 0 cycles. `o_rdata` follows `i_raddr` and the stored contents combinationally.
- Same-cycle read/write of one index, without the bypass feature: the read returns the old value until the edge, then the new value.
- Repeated writes to the same index on consecutive edges: each edge overwrites, and the last write wins.
- No handshake, no stalls, no state machine.

## Configuration
- `COTM32_REGFILE_BYPASS_EN` defined: write-to-read forwarding is enabled.
  - If `i_we`=1, `i_waddr`!=0 and `i_raddr[p]`==`i_waddr`, then `o_rdata[p]` = `i_wdata` combinationally in the same cycle.
  - Forwarding never applies to x0 and never applies during reset.
- Macro undefined: no forwarding. Reads return only committed storage, as described in Timing.

## Test plan
- After reset, with default parameters: write x1=0x12345600 on one edge, then deassert `we` and set raddr[0]=1 -> rdata[0]=0x12345600.
- Write x15=0xABCDEF00, then set raddr[1]=15 with raddr[0]=1 -> rdata[0]=0x12345600 and rdata[1]=0xABCDEF00.
- Write x31=0xAABBCCDD, then set raddr[0]=31 and raddr[1]=1 -> rdata[0]=0xAABBCCDD and rdata[1]=0x12345600.
- Write x0=0xCCDDEEFF, then set raddr[0]=0 -> rdata[0]=0.
- Hold we=1, waddr=2, raddr[0]=2 and drive wdata 1, 2, 3 on successive edges -> after each edge rdata[0] equals 1, 2, 3 respectively. Before the first edge, rdata[0]=0 without bypass, or 1 with `COTM32_REGFILE_BYPASS_EN`.
- Assert `i_rst_n`=0 asynchronously between edges after the writes above -> all rdata go to 0 immediately. After release, reading x1, x15 and x31 -> 0.
